// File: rtl/uart_rx_if.sv
// Received-byte stream between the UART receiver and its consumer.
// The master side (receiver) drives byte and valid; the slave side drives ready.
// A byte transfers on any clk edge where valid and ready are both high.
interface uart_rx_if;
  logic [7:0] rx_d_o;
  logic       rx_d_valid_o;
  logic       rx_d_ready_i;

  modport master (output rx_d_o, output rx_d_valid_o, input rx_d_ready_i);
  modport slave  (input rx_d_o, input rx_d_valid_o, output rx_d_ready_i);
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8 data bits, optional even parity via UART_RX_PARITY_EN).
// Latency: byte valid the clk after the stop-bit sample tick; 1-entry holding register.
// Backpressure: rts_n_o high while holding register full; a byte completing into a full register is dropped (overrun).
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        rx_enable_i,
  input  logic        rx_i,
  output logic        rts_n_o,
  input  logic        clear_err_i,
  output logic [2:0]  rx_status_o,
  uart_rx_if.master   rx_d_if
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            hold_vld_q, hold_vld_d;
  logic [7:0]      hold_dat_q, hold_dat_d;
  logic            rts_n_q, rts_n_d;
  logic [2:0]      status_q, status_d;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  logic rx_s;
  logic byte_good, frame_err_set, par_err_set, overrun_set, accept;

  assign rx_s = sync2_q;

  // Receive FSM, synchronizer, holding register, flow control and sticky status
  always_comb begin
    state_d       = state_q;
    sync1_d       = rx_i;
    sync2_d       = sync1_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    hold_vld_d    = hold_vld_q;
    hold_dat_d    = hold_dat_q;
    byte_good     = 1'b0;
    frame_err_set = 1'b0;
    par_err_set   = 1'b0;
    overrun_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d     = par_err_q;
`endif

    if (!rx_enable_i) begin
      // Disabling aborts any frame in flight silently; held byte is kept.
      state_d    = IDLE;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = '0;
          end
        end
        START: begin
          // Re-check the line mid start bit to reject short glitches.
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d  = '0;
            par_err_d   = (^shift_q) ^ rx_s;
            par_err_set = (^shift_q) ^ rx_s;
            state_d     = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
`ifdef UART_RX_PARITY_EN
              byte_good = !par_err_q;
`else
              byte_good = 1'b1;
`endif
            end else begin
              frame_err_set = 1'b1;
              state_d       = WAIT_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // Hold off re-arming until a break condition has ended.
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    accept = hold_vld_q & rx_d_if.rx_d_ready_i;
    if (byte_good) begin
      if (!hold_vld_q || accept) begin
        hold_vld_d = 1'b1;
        hold_dat_d = shift_q;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (accept) begin
      hold_vld_d = 1'b0;
    end

    rts_n_d  = !rx_enable_i || hold_vld_d;

    // Clear first so a coincident event still lands in the sticky bits.
    status_d = clear_err_i ? 3'b000 : status_q;
    status_d = status_d | {overrun_set, par_err_set, frame_err_set};
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= 8'h00;
      hold_vld_q <= 1'b0;
      hold_dat_q <= 8'h00;
      rts_n_q    <= 1'b1;
      status_q   <= 3'b000;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
      rts_n_q    <= rts_n_d;
      status_q   <= status_d;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_d_if.rx_d_o       = hold_dat_q;
  assign rx_d_if.rx_d_valid_o = hold_vld_q;
  assign rts_n_o              = rts_n_q;
  assign rx_status_o          = status_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: frames are built bit by bit from the UART framing rules,
// the line is driven one tick at a time, and received bytes / status are compared
// against expectations derived from the frame contents.
module tb_uart_rx;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Start detected one tick after the falling edge, start re-checked half a bit
  // later, then every following bit sampled one full bit-time apart.
  localparam int STOP_TICK = 1 + OS / 2 + OS * (NB - 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_i = 1'b0;
  logic       rx_enable_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       rts_n_o;
  logic       clear_err_i = 1'b0;
  logic [2:0] rx_status_o;

  uart_rx_if rxd ();

  int errors = 0;
  int checks = 0;
  int tcnt = 0;
  logic [7:0] rcv_q[$];

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .rx_enable_i (rx_enable_i),
    .rx_i        (rx_i),
    .rts_n_o     (rts_n_o),
    .clear_err_i (clear_err_i),
    .rx_status_o (rx_status_o),
    .rx_d_if     (rxd)
  );

  always #5 clk = ~clk;

  // Sample-enable pulse every 4 clks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tcnt   = (tcnt + 1) % 4;
      tick_i = (tcnt == 0);
    end
  end

  // Capture every completed handshake.
  always @(negedge clk) begin
    if (!rst && rxd.rx_d_valid_o && rxd.rx_d_ready_i) rcv_q.push_back(rxd.rx_d_o);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick_i !== 1'b1);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_err_i = 1'b1;
    @(posedge clk); #1 clear_err_i = 1'b0;
  endtask

  task automatic accept_one();
    @(posedge clk); #1 rxd.rx_d_ready_i = 1'b1;
    @(posedge clk); #1 rxd.rx_d_ready_i = 1'b0;
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] d, input bit bad_par, input bit stop_v);
    logic [10:0] fr;
    fr       = 11'h7FF;
    fr[0]    = 1'b0;
    fr[8:1]  = d;
`ifdef UART_RX_PARITY_EN
    fr[9]    = (^d) ^ bad_par;
    fr[10]   = stop_v;
`else
    fr[9]    = stop_v;
`endif
    return fr;
  endfunction

  // mode 0: plain; 1: check valid rises exactly after the stop sample tick;
  // 2: raise ready only for the stop-sample clk so acceptance coincides with completion.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop_v,
                            input int mode, input logic end_lvl);
    logic [10:0] fr;
    fr = build_frame(d, bad_par, stop_v);
    wait_tick();
    rx_i = fr[0];
    for (int k = 1; k <= NB * OS; k++) begin
      if (mode == 2 && k == STOP_TICK) begin
        repeat (3) @(posedge clk);
        #1 rxd.rx_d_ready_i = 1'b1;
      end
      wait_tick();
      if (mode == 2 && k == STOP_TICK) rxd.rx_d_ready_i = 1'b0;
      if (mode == 1 && k == STOP_TICK - 1) begin
        checks++;
        if (rxd.rx_d_valid_o !== 1'b0) begin
          errors++; $display("FAIL early_valid: got %b exp 0", rxd.rx_d_valid_o);
        end
      end
      if (mode == 1 && k == STOP_TICK) begin
        checks++;
        if (rxd.rx_d_valid_o !== 1'b1 || rxd.rx_d_o !== d) begin
          errors++; $display("FAIL valid_timing: got vld=%b dat=%h exp vld=1 dat=%h",
                             rxd.rx_d_valid_o, rxd.rx_d_o, d);
        end
      end
      rx_i = (k < NB * OS) ? fr[k / OS] : end_lvl;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (rxd.rx_d_o !== 8'h00 || rxd.rx_d_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_data: got dat=%h vld=%b exp 00/0", rxd.rx_d_o, rxd.rx_d_valid_o);
    end
    checks++;
    if (rts_n_o !== 1'b1) begin errors++; $display("FAIL reset_rts: got %b exp 1", rts_n_o); end
    checks++;
    if (rx_status_o !== 3'b000) begin errors++; $display("FAIL reset_status: got %b exp 000", rx_status_o); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (rts_n_o !== 1'b1) begin errors++; $display("FAIL rts_disabled: got %b exp 1", rts_n_o); end
    rx_enable_i = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (rts_n_o !== 1'b0) begin errors++; $display("FAIL rts_enabled: got %b exp 0", rts_n_o); end
  endtask

  task automatic test_basic();
    logic [7:0] b;
`ifdef UART_RX_PARITY_EN
    b = 8'hA5;
`else
    b = 8'h3C;
`endif
    rxd.rx_d_ready_i = 1'b0;
    send_frame(b, 1'b0, 1'b1, 1, 1'b1);
    idle_ticks(OS);
    checks++;
    if (rxd.rx_d_o !== b || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL basic_byte: got dat=%h st=%b exp dat=%h st=000", rxd.rx_d_o, rx_status_o, b);
    end
    checks++;
    if (rts_n_o !== 1'b1) begin errors++; $display("FAIL basic_rts_full: got %b exp 1", rts_n_o); end
    accept_one();
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rts_n_o !== 1'b0) begin
      errors++; $display("FAIL basic_accept: got vld=%b rts_n=%b exp 0/0", rxd.rx_d_valid_o, rts_n_o);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b1);
    idle_ticks(OS);
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rx_status_o !== 3'b010) begin
      errors++; $display("FAIL parity_err: got vld=%b st=%b exp 0/010", rxd.rx_d_valid_o, rx_status_o);
    end
    pulse_clear();
    checks++;
    if (rx_status_o !== 3'b000) begin errors++; $display("FAIL parity_clear: got %b exp 000", rx_status_o); end
  endtask
`endif

  task automatic test_break();
    send_frame(8'h00, 1'b0, 1'b0, 0, 1'b0);
    idle_ticks(2 * OS);
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rx_status_o !== 3'b001) begin
      errors++; $display("FAIL frame_err: got vld=%b st=%b exp 0/001", rxd.rx_d_valid_o, rx_status_o);
    end
    // A receiver that re-armed during the break would flag fresh frame errors.
    pulse_clear();
    idle_ticks(18 * OS);
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL break_hold: got vld=%b st=%b exp 0/000", rxd.rx_d_valid_o, rx_status_o);
    end
    rx_i = 1'b1;
    idle_ticks(2 * OS);
    send_frame(8'hC3, 1'b0, 1'b1, 1, 1'b1);
    idle_ticks(OS);
    accept_one();
  endtask

  task automatic test_glitch();
    wait_tick();
    rx_i = 1'b0;
    idle_ticks(4);
    rx_i = 1'b1;
    idle_ticks(2 * OS);
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL glitch: got vld=%b st=%b exp 0/000", rxd.rx_d_valid_o, rx_status_o);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1, 1'b1);
    idle_ticks(OS);
    accept_one();
  endtask

  task automatic test_overrun();
    rxd.rx_d_ready_i = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1, 1'b1);
    idle_ticks(2);
    checks++;
    if (rts_n_o !== 1'b1) begin errors++; $display("FAIL overrun_rts: got %b exp 1", rts_n_o); end
    idle_ticks(OS);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
    idle_ticks(OS);
    checks++;
    if (rxd.rx_d_o !== 8'h11 || rxd.rx_d_valid_o !== 1'b1 || rx_status_o !== 3'b100) begin
      errors++; $display("FAIL overrun: got dat=%h vld=%b st=%b exp 11/1/100",
                         rxd.rx_d_o, rxd.rx_d_valid_o, rx_status_o);
    end
    pulse_clear();
    send_frame(8'h33, 1'b0, 1'b1, 2, 1'b1);
    idle_ticks(OS);
    checks++;
    if (rxd.rx_d_o !== 8'h33 || rxd.rx_d_valid_o !== 1'b1 || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL back_to_back: got dat=%h vld=%b st=%b exp 33/1/000",
                         rxd.rx_d_o, rxd.rx_d_valid_o, rx_status_o);
    end
    accept_one();
  endtask

  task automatic test_enable_abort();
    rxd.rx_d_ready_i = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 0, 1'b1);
    idle_ticks(OS);
    wait_tick();
    rx_i = 1'b0;
    idle_ticks(5 * OS);
    rx_enable_i = 1'b0;
    idle_ticks(2);
    rx_i = 1'b1;
    idle_ticks(OS);
    rx_enable_i = 1'b1;
    idle_ticks(2 * OS);
    checks++;
    if (rxd.rx_d_o !== 8'h77 || rxd.rx_d_valid_o !== 1'b1 || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL enable_abort: got dat=%h vld=%b st=%b exp 77/1/000",
                         rxd.rx_d_o, rxd.rx_d_valid_o, rx_status_o);
    end
    accept_one();
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [2:0] exp_st;
    logic [7:0] d;
    bit bad_stop, bad_par;
    rcv_q.delete();
    exp_st = 3'b000;
    rxd.rx_d_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d        = 8'($urandom);
      bad_stop = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
      bad_par  = ($urandom_range(0, 3) == 0);
`else
      bad_par  = 1'b0;
`endif
      send_frame(d, bad_par, !bad_stop, 0, 1'b1);
      idle_ticks(2 * OS);
      if (!bad_stop && !bad_par) exp_q.push_back(d);
      if (bad_stop) exp_st[0] = 1'b1;
      if (bad_par)  exp_st[1] = 1'b1;
    end
    rxd.rx_d_ready_i = 1'b0;
    checks++;
    if (rcv_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d exp %0d", rcv_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (rcv_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random_byte[%0d]: got %h exp %h", i, rcv_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (rx_status_o !== exp_st) begin errors++; $display("FAIL random_status: got %b exp %b", rx_status_o, exp_st); end
    pulse_clear();
  endtask

  task automatic test_reset_mid();
    rxd.rx_d_ready_i = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b1);
    idle_ticks(OS);
    wait_tick();
    rx_i = 1'b0;
    idle_ticks(4 * OS);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rxd.rx_d_o !== 8'h00 || rxd.rx_d_valid_o !== 1'b0 || rts_n_o !== 1'b1 || rx_status_o !== 3'b000) begin
      errors++; $display("FAIL reset_mid: got dat=%h vld=%b rts_n=%b st=%b exp 00/0/1/000",
                         rxd.rx_d_o, rxd.rx_d_valid_o, rts_n_o, rx_status_o);
    end
    rx_i = 1'b1;
    rst  = 1'b0;
    idle_ticks(NB * OS);
    checks++;
    if (rxd.rx_d_valid_o !== 1'b0 || rts_n_o !== 1'b0) begin
      errors++; $display("FAIL reset_discard: got vld=%b rts_n=%b exp 0/0", rxd.rx_d_valid_o, rts_n_o);
    end
  endtask

  initial begin
    rxd.rx_d_ready_i = 1'b0;
    test_reset();
    test_basic();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_break();
    test_glitch();
    test_overrun();
    test_enable_abort();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit (even, 8..64).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port tick_i  input  1  one-clk sample-enable pulse at OVERSAMPLE x baud.
REQ-005 SHALL have port rx_enable_i  input  1  receiver enable.
REQ-006 SHALL have port rx_i  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rts_n_o  output  1  flow control; low = ready to receive.
REQ-008 SHALL have port rx_d_o  output  8  received byte.
REQ-009 SHALL have port rx_d_valid_o  output  1  byte valid.
REQ-010 SHALL have port rx_d_ready_i  input  1  downstream accepts byte.
REQ-011 SHALL have port clear_err_i  input  1  one-cycle clear of sticky errors.
REQ-012 SHALL have port rx_status_o  output  3  {overrun, parity_err, frame_err}, sticky.

Function
REQ-013 SHALL pass rx_i through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; tick counter and bit counter advance only on tick_i.
REQ-015 IDLE: on tick with rx_enable_i=1 and synchronized line low -> START, tick counter cleared.
REQ-016 START: after OVERSAMPLE/2 ticks sample line; low -> DATA, high -> IDLE (glitch rejected, no error).
REQ-017 DATA: sample every OVERSAMPLE ticks, 8 bits LSB first into shift register; after bit 7 -> PARITY (macro on) or STOP.
REQ-018 PARITY: sample one bit; parity error when XOR of 8 data bits and parity bit is 1 (even parity).
REQ-019 STOP: sample one bit; high = valid stop -> IDLE; low -> frame_err set, WAIT_IDLE.
REQ-020 WAIT_IDLE: remain until synchronized line high on a tick, then IDLE (break handling).
REQ-021 Byte with frame or parity error SHALL be discarded, not presented.
REQ-022 Good byte SHALL load 1-entry holding register; rx_d_valid_o rises the clk cycle after the stop-bit sample tick.
REQ-023 rx_d_o/rx_d_valid_o SHALL hold stable until rx_d_valid_o & rx_d_ready_i; valid drops next cycle unless a new byte loads the same cycle.
REQ-024 Good byte completing while holding register full and not accepted that cycle SHALL be dropped and set overrun; held byte unchanged.
REQ-025 Completion in the same cycle as acceptance SHALL load the new byte with no overrun.
REQ-026 rts_n_o SHALL be 1 when rx_enable_i=0 or holding register full, else 0; registered.
REQ-027 rx_enable_i falling mid-frame SHALL abort to IDLE without error; holding register retained.
REQ-028 Sticky bits SHALL set on event and clear on clear_err_i; simultaneous set and clear -> set wins.

Reset
REQ-029 On rst: state IDLE, counters 0, synchronizer flops 1, rx_d_o 8'h00, rx_d_valid_o 0, rts_n_o 1, rx_status_o 3'b000.
REQ-030 rst mid-frame SHALL discard the partial byte and any held byte.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: 11-bit frame (start, 8 data, even parity, stop), PARITY state present.
REQ-032 Macro undefined: 10-bit frame (8N1), PARITY state and checker absent, rx_status_o[1] tied 0.

Verification
REQ-033 Macro on, OVERSAMPLE=16, 0xA5 parity 0 stop 1 -> rx_d_o=0xA5, valid one clk after stop tick, status 000.
REQ-034 0x01 with parity bit 0 -> no valid, rx_status_o=010; clear_err_i -> 000.
REQ-035 Stop bit low then line low 20 bit-times -> no valid, status 001, state WAIT_IDLE until line high.
REQ-036 Line low 4 ticks then high -> no byte, no error, back to IDLE.
REQ-037 rx_d_ready_i=0, send 0x11 then 0x22 -> rx_d_o stays 0x11, overrun=1, rts_n_o=1 after first byte.
REQ-038 Macro off, 0x3C 8N1 -> rx_d_o=0x3C; rst asserted mid-byte -> all outputs at reset values.
